// File: rtl/wb_pkg.sv
// Shared definitions for the GPR write-back path: widths, source encoding,
// hold-entry type, hold FSM states and the round-robin pick helper.
package wb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int REGIDX_W = 5;

    // Result sources; the numeric value doubles as the request/grant bit index.
    typedef enum logic [1:0] {
        SRC_MEM = 2'd0,
        SRC_CSR = 2'd1,
        SRC_ALU = 2'd2
    } wb_src_e;

    // One held result waiting for the GPR write port.
    typedef struct packed {
        logic                valid;
        logic [REGIDX_W-1:0] rd;
        logic [XLEN_DEF-1:0] data;
    } wb_entry_t;

    // Hold register life cycle: DRAIN keeps ready low for one cycle after the
    // entry has been granted, so a slot cannot be refilled back-to-back.
    typedef enum logic [1:0] {
        HOLD_EMPTY = 2'd0,
        HOLD_FULL  = 2'd1,
        HOLD_DRAIN = 2'd2
    } hold_state_e;

    // Round-robin pick in the order MEM -> CSR -> ALU, starting after last_s.
    // When nothing else requests, last_s itself is returned; the caller
    // qualifies the result with |req_s.
    function automatic wb_src_e rr_pick(input wb_src_e last_s, input logic [2:0] req_s);
        wb_src_e pick_s;
        case (last_s)
            SRC_MEM: pick_s = req_s[SRC_CSR] ? SRC_CSR : (req_s[SRC_ALU] ? SRC_ALU : SRC_MEM);
            SRC_CSR: pick_s = req_s[SRC_ALU] ? SRC_ALU : (req_s[SRC_MEM] ? SRC_MEM : SRC_CSR);
            SRC_ALU: pick_s = req_s[SRC_MEM] ? SRC_MEM : (req_s[SRC_CSR] ? SRC_CSR : SRC_ALU);
            default: pick_s = SRC_MEM;
        endcase
        return pick_s;
    endfunction

endpackage

// File: rtl/gpr_writeback_if.sv
// Bundle of the write-back handshakes, GPR write port and scoreboard query
// signals. The slave modport is the write-back block, master is its environment.
interface gpr_writeback_if #(
    parameter int XLEN = wb_pkg::XLEN_DEF
);
    import wb_pkg::*;

    logic                iss_valid;
    logic [REGIDX_W-1:0] iss_rd;

    logic                alu_valid;
    logic                alu_ready;
    logic [REGIDX_W-1:0] alu_rd;
    logic [XLEN-1:0]     alu_data;

    logic                mem_valid;
    logic                mem_ready;
    logic [REGIDX_W-1:0] mem_rd;
    logic [XLEN-1:0]     mem_data;

    logic                csr_valid;
    logic                csr_ready;
    logic [REGIDX_W-1:0] csr_rd;
    logic [XLEN-1:0]     csr_data;

    logic                gpr_we;
    logic [REGIDX_W-1:0] gpr_rd;
    logic [XLEN-1:0]     gpr_di;

    logic [REGIDX_W-1:0] chk_ra;
    logic [REGIDX_W-1:0] chk_rb;
    logic [REGIDX_W-1:0] chk_rd;
    logic                busy_a;
    logic                busy_b;
    logic                busy_d;

    modport slave (
        input  iss_valid, iss_rd,
        input  alu_valid, alu_rd, alu_data, output alu_ready,
        input  mem_valid, mem_rd, mem_data, output mem_ready,
        input  csr_valid, csr_rd, csr_data, output csr_ready,
        output gpr_we, gpr_rd, gpr_di,
        input  chk_ra, chk_rb, chk_rd,
        output busy_a, busy_b, busy_d
    );

    modport master (
        output iss_valid, iss_rd,
        output alu_valid, alu_rd, alu_data, input alu_ready,
        output mem_valid, mem_rd, mem_data, input mem_ready,
        output csr_valid, csr_rd, csr_data, input csr_ready,
        input  gpr_we, gpr_rd, gpr_di,
        output chk_ra, chk_rb, chk_rd,
        input  busy_a, busy_b, busy_d
    );

endinterface

// File: rtl/gpr_writeback_chk.sv
// Protocol checks for the write-back scoreboard: no issue to a busy register
// and no result for a register that has no write in flight.
module gpr_writeback_chk
    import wb_pkg::*;
#(
    parameter int NREG = NREG_DEF
) (
    input logic                clk,
    input logic                rst,
    input logic                iss_valid,
    input logic [REGIDX_W-1:0] iss_rd,
    input logic [NREG-1:0]     busy,
    input logic                gpr_we,
    input logic [REGIDX_W-1:0] gpr_rd,
    input logic [2:0]          acc,
    input logic [REGIDX_W-1:0] mem_rd,
    input logic [REGIDX_W-1:0] csr_rd,
    input logic [REGIDX_W-1:0] alu_rd
);

    // Re-issuing to a register whose clear lands on this same edge is allowed.
    property p_issue_free;
        @(posedge clk) disable iff (rst)
        (iss_valid && (iss_rd != 5'd0) && !(gpr_we && (gpr_rd == iss_rd))) |-> !busy[iss_rd];
    endproperty
    a_issue_free: assert property (p_issue_free);

    property p_result_busy(logic a, logic [REGIDX_W-1:0] rd);
        @(posedge clk) disable iff (rst)
        (a && (rd != 5'd0)) |-> busy[rd];
    endproperty
    a_mem_busy: assert property (p_result_busy(acc[SRC_MEM], mem_rd));
    a_csr_busy: assert property (p_result_busy(acc[SRC_CSR], csr_rd));
    a_alu_busy: assert property (p_result_busy(acc[SRC_ALU], alu_rd));

endmodule

// File: rtl/wb_hold.sv
// One-entry valid/ready hold register for a single result source.
module wb_hold
    import wb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [REGIDX_W-1:0] in_rd,
    input  logic [XLEN_DEF-1:0] in_data,
    input  logic                grant,
    output wb_entry_t           entry
);

    hold_state_e         state_r;
    hold_state_e         state_next_s;
    logic                load_s;
    logic [REGIDX_W-1:0] rd_r;
    logic [XLEN_DEF-1:0] data_r;

    // Hold FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= HOLD_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: accept when empty, leave on grant, one drain cycle before reuse.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        case (state_r)
            HOLD_EMPTY: begin
                load_s       = in_valid;
                state_next_s = in_valid ? HOLD_FULL : HOLD_EMPTY;
            end
            HOLD_FULL:  state_next_s = grant ? HOLD_DRAIN : HOLD_FULL;
            HOLD_DRAIN: state_next_s = HOLD_EMPTY;
            default:    state_next_s = HOLD_EMPTY;
        endcase
    end

    // Payload capture on an accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_r   <= {REGIDX_W{1'b0}};
            data_r <= {XLEN_DEF{1'b0}};
        end else if (load_s) begin
            rd_r   <= in_rd;
            data_r <= in_data;
        end else begin
            rd_r   <= rd_r;
            data_r <= data_r;
        end
    end

    // Entry view and ready, both decoded straight from registers.
    always_comb begin
        in_ready   = (state_r == HOLD_EMPTY);
        entry.valid = (state_r == HOLD_FULL);
        entry.rd    = rd_r;
        entry.data  = data_r;
    end

endmodule

// File: rtl/gpr_writeback.sv
// GPR write-back initiator: three hold registers, round-robin arbiter,
// registered GPR write port and per-register busy scoreboard.
module gpr_writeback
    import wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic            clk,
    input  logic            rst,
    gpr_writeback_if.slave  bus
);

    wb_entry_t           mem_e_s;
    wb_entry_t           csr_e_s;
    wb_entry_t           alu_e_s;
    wb_entry_t           win_s;
    logic [2:0]          req_s;
    logic [2:0]          grant_s;
    logic [2:0]          acc_s;
    logic                any_s;
    wb_src_e             pick_s;
    wb_src_e             last_r;

    logic                gpr_we_r;
    logic [REGIDX_W-1:0] gpr_rd_r;
    logic [XLEN-1:0]     gpr_di_r;
    logic [NREG-1:0]     busy_r;
    logic [NREG-1:0]     busy_next_s;

    wb_hold u_mem_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.mem_valid),
        .in_ready (bus.mem_ready),
        .in_rd    (bus.mem_rd),
        .in_data  (bus.mem_data),
        .grant    (grant_s[SRC_MEM]),
        .entry    (mem_e_s)
    );

    wb_hold u_csr_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.csr_valid),
        .in_ready (bus.csr_ready),
        .in_rd    (bus.csr_rd),
        .in_data  (bus.csr_data),
        .grant    (grant_s[SRC_CSR]),
        .entry    (csr_e_s)
    );

    wb_hold u_alu_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.alu_valid),
        .in_ready (bus.alu_ready),
        .in_rd    (bus.alu_rd),
        .in_data  (bus.alu_data),
        .grant    (grant_s[SRC_ALU]),
        .entry    (alu_e_s)
    );

    // Round-robin arbitration among held entries and winner selection.
    always_comb begin
        req_s      = 3'b000;
        req_s[SRC_MEM] = mem_e_s.valid;
        req_s[SRC_CSR] = csr_e_s.valid;
        req_s[SRC_ALU] = alu_e_s.valid;
        any_s      = |req_s;
        pick_s     = rr_pick(last_r, req_s);
        grant_s    = 3'b000;
        grant_s[SRC_MEM] = any_s && (pick_s == SRC_MEM);
        grant_s[SRC_CSR] = any_s && (pick_s == SRC_CSR);
        grant_s[SRC_ALU] = any_s && (pick_s == SRC_ALU);
        case (pick_s)
            SRC_MEM: win_s = mem_e_s;
            SRC_CSR: win_s = csr_e_s;
            SRC_ALU: win_s = alu_e_s;
            default: win_s = mem_e_s;
        endcase
        acc_s      = 3'b000;
        acc_s[SRC_MEM] = bus.mem_valid && bus.mem_ready;
        acc_s[SRC_CSR] = bus.csr_valid && bus.csr_ready;
        acc_s[SRC_ALU] = bus.alu_valid && bus.alu_ready;
    end

    // Winner into the GPR write register; x0 slots update address/data only.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpr_we_r <= 1'b0;
            gpr_rd_r <= {REGIDX_W{1'b0}};
            gpr_di_r <= {XLEN{1'b0}};
            last_r   <= SRC_ALU;
        end else if (any_s) begin
            gpr_we_r <= (win_s.rd != 5'd0);
            gpr_rd_r <= win_s.rd;
            gpr_di_r <= win_s.data;
            last_r   <= pick_s;
        end else begin
            gpr_we_r <= 1'b0;
            gpr_rd_r <= gpr_rd_r;
            gpr_di_r <= gpr_di_r;
            last_r   <= last_r;
        end
    end

    // Scoreboard next value: clear on the write cycle, issue set takes priority.
    always_comb begin
        busy_next_s = busy_r;
        for (int i = 1; i < NREG; i++) begin
            busy_next_s[i] = (bus.iss_valid && (bus.iss_rd == i[REGIDX_W-1:0])) ? 1'b1 :
                             ((gpr_we_r && (gpr_rd_r == i[REGIDX_W-1:0])) ? 1'b0 : busy_r[i]);
        end
        busy_next_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    assign bus.gpr_we = gpr_we_r;
    assign bus.gpr_rd = gpr_rd_r;
    assign bus.gpr_di = gpr_di_r;
    assign bus.busy_a = busy_r[bus.chk_ra];
    assign bus.busy_b = busy_r[bus.chk_rb];
    assign bus.busy_d = busy_r[bus.chk_rd];

    gpr_writeback_chk #(.NREG(NREG)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (bus.iss_valid),
        .iss_rd    (bus.iss_rd),
        .busy      (busy_r),
        .gpr_we    (gpr_we_r),
        .gpr_rd    (gpr_rd_r),
        .acc       (acc_s),
        .mem_rd    (bus.mem_rd),
        .csr_rd    (bus.csr_rd),
        .alu_rd    (bus.alu_rd)
    );

endmodule
